// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI shift-register transfer engine.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_e;

  localparam int unsigned DATA_W_MIN = 8;
  localparam int unsigned DATA_W_MAX = 128;
  // Wide enough to hold N = DATA_W_MAX.
  localparam int unsigned N_W = 8;

  // A zero length field encodes a full-width character.
  function automatic logic [N_W-1:0] len_to_n(input logic [N_W-1:0] len,
                                             input logic [N_W-1:0] data_w);
    return (len == '0) ? data_w : len;
  endfunction

  function automatic bit data_w_legal(input int unsigned w);
    return (w >= DATA_W_MIN) && (w <= DATA_W_MAX) && ((w % 8) == 0);
  endfunction

endpackage

// File: rtl/spi_shift_xfer_if.sv
// Parallel/serial bus of the SPI shift engine. loop_en exists only when
// SPI_SHIFT_LOOPBACK_EN is defined.
interface spi_shift_xfer_if #(
  parameter int DATA_W = 32,
  parameter int LEN_W  = $clog2(DATA_W)
);
  logic              go;
  logic [LEN_W-1:0]  len;
  logic              lsb;
  logic              tx_negedge;
  logic              rx_negedge;
  logic              pos_edge;
  logic              neg_edge;
  logic              miso;
  logic              wr;
  logic [DATA_W/8-1:0] byte_sel;
  logic [DATA_W-1:0] p_in;
  logic [DATA_W-1:0] p_out;
  logic              mosi;
  logic              tip;
  logic              last;
  logic              done;
`ifdef SPI_SHIFT_LOOPBACK_EN
  logic              loop_en;
`endif

  modport master (
    output go, len, lsb, tx_negedge, rx_negedge, pos_edge, neg_edge, miso,
    output wr, byte_sel, p_in,
`ifdef SPI_SHIFT_LOOPBACK_EN
    output loop_en,
`endif
    input  p_out, mosi, tip, last, done
  );

  modport slave (
    input  go, len, lsb, tx_negedge, rx_negedge, pos_edge, neg_edge, miso,
    input  wr, byte_sel, p_in,
`ifdef SPI_SHIFT_LOOPBACK_EN
    input  loop_en,
`endif
    output p_out, mosi, tip, last, done
  );
endinterface

// File: rtl/spi_bit_ctr.sv
// Loadable bit down-counter; remembers the loaded length so it can turn the
// count into a bit index for either shift order.
module spi_bit_ctr #(
  parameter int CW    = 6,
  parameter int IDX_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             dec_i,
  input  logic             lsb_i,
  input  logic [CW-1:0]    n_i,
  output logic             zero_o,
  output logic [IDX_W-1:0] idx_o
);
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] n_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      n_q   <= '0;
    end else if (load_i) begin
      cnt_q <= n_i;
      n_q   <= n_i;
    end else if (dec_i && !zero_o) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  assign zero_o = (cnt_q == '0);
  // MSB-first walks down from N-1; LSB-first walks up from 0.
  assign idx_o  = lsb_i ? IDX_W'(n_q - cnt_q) : IDX_W'(cnt_q - CW'(1));

endmodule

// File: rtl/spi_shift_xfer.sv
// SPI shift-register transfer engine (IDLE/SHIFT/DONE). Define
// SPI_SHIFT_LOOPBACK_EN to add loop_en, which samples the registered mosi.
module spi_shift_xfer
  import spi_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int LEN_W  = $clog2(DATA_W)
) (
  input logic             wb_clk,
  input logic             wb_reset,
  spi_shift_xfer_if.slave bus
);
  localparam int CW = LEN_W + 1;

  state_e            state_q;
  logic [DATA_W-1:0] data_q, data_d;
  logic              mosi_q, tip_q, done_q;
  logic              lsb_q, tx_neg_q, rx_neg_q;

  logic              start;
  logic              tx_stb, rx_stb, tx_fire, rx_fire;
  logic              tx_zero, rx_zero, rx_src;
  logic [LEN_W-1:0]  tx_idx, rx_idx;
  logic [CW-1:0]     n_load;

  assign start   = (state_q == ST_IDLE) && bus.go;
  assign n_load  = CW'(len_to_n(N_W'(bus.len), N_W'(DATA_W)));
  assign tx_stb  = tx_neg_q ? bus.neg_edge : bus.pos_edge;
  assign rx_stb  = rx_neg_q ? bus.neg_edge : bus.pos_edge;
  assign tx_fire = (state_q == ST_SHIFT) && tx_stb && !tx_zero;
  assign rx_fire = (state_q == ST_SHIFT) && rx_stb && !rx_zero;

`ifdef SPI_SHIFT_LOOPBACK_EN
  assign rx_src = bus.loop_en ? mosi_q : bus.miso;
`else
  assign rx_src = bus.miso;
`endif

  spi_bit_ctr #(.CW(CW), .IDX_W(LEN_W)) u_tx_ctr (
    .clk_i  (wb_clk),
    .rst_i  (wb_reset),
    .load_i (start),
    .dec_i  (tx_fire),
    .lsb_i  (lsb_q),
    .n_i    (n_load),
    .zero_o (tx_zero),
    .idx_o  (tx_idx)
  );

  spi_bit_ctr #(.CW(CW), .IDX_W(LEN_W)) u_rx_ctr (
    .clk_i  (wb_clk),
    .rst_i  (wb_reset),
    .load_i (start),
    .dec_i  (rx_fire),
    .lsb_i  (lsb_q),
    .n_i    (n_load),
    .zero_o (rx_zero),
    .idx_o  (rx_idx)
  );

  // Byte-enabled parallel write, applied only while idle.
  always_comb begin
    // NOTE: default assignment first so no path leaves data_d unassigned (no latch).
    data_d = data_q;
    if (bus.wr) begin
      for (int k = 0; k < DATA_W/8; k++) begin
        if (bus.byte_sel[k]) data_d[8*k +: 8] = bus.p_in[8*k +: 8];
      end
    end
  end

  // NOTE: non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge wb_clk) begin
    if (wb_reset) begin
      // NOTE: data_q is a flat register, not a RAM, so it is cleared here too.
      state_q  <= ST_IDLE;
      data_q   <= '0;
      mosi_q   <= 1'b0;
      tip_q    <= 1'b0;
      done_q   <= 1'b0;
      lsb_q    <= 1'b0;
      tx_neg_q <= 1'b0;
      rx_neg_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          data_q <= data_d;
          if (bus.go) begin
            state_q  <= ST_SHIFT;
            tip_q    <= 1'b1;
            lsb_q    <= bus.lsb;
            tx_neg_q <= bus.tx_negedge;
            rx_neg_q <= bus.rx_negedge;
          end
        end
        ST_SHIFT: begin
          // A coincident rx write does not disturb the bit being driven.
          if (tx_fire) mosi_q <= data_q[tx_idx];
          if (rx_fire) data_q[rx_idx] <= rx_src;
          if (rx_zero) begin
            state_q <= ST_DONE;
            tip_q   <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.p_out = data_q;
  assign bus.mosi  = mosi_q;
  assign bus.tip   = tip_q;
  assign bus.done  = done_q;
  assign bus.last  = tip_q && tx_zero;

endmodule

// File: tb/tb_spi_shift_xfer.sv
// Scoreboard bench for spi_shift_xfer: stimulus pushes expected transfers,
// a monitor collects mosi bits and compares on every done pulse.
module tb_spi_shift_xfer;
  localparam int DW = 32;
  localparam int LW = $clog2(DW);
  localparam int BW = DW/8;

  logic wb_clk = 1'b0;
  logic wb_reset;
  always #5 wb_clk = ~wb_clk;

  spi_shift_xfer_if #(.DATA_W(DW)) bus ();
  spi_shift_xfer #(.DATA_W(DW)) dut (.wb_clk(wb_clk), .wb_reset(wb_reset), .bus(bus));

  logic ext_loop, miso_drv;
  assign bus.miso = ext_loop ? bus.mosi : miso_drv;

  typedef struct {
    int            n;
    bit            tx_neg;
    logic [DW-1:0] mosi_exp;
    logic [DW-1:0] pout_exp;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] model_d;
  int            n_tests = 0;
  int            n_fail  = 0;

  task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge wb_clk);
    #1;
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [BW-1:0] sel,
                                          input logic [DW-1:0] din);
    logic [DW-1:0] r;
    r = old;
    for (int k = 0; k < BW; k++) if (sel[k]) r[8*k +: 8] = din[8*k +: 8];
    return r;
  endfunction

  // Monitor: collect mosi after each selected tx strobe, score on done.
  logic [DW-1:0] got_mosi;
  int            got_n = 0;
  bit            cap_pend = 0;
  exp_t          e_mon;
  logic [DW-1:0] msk;

  initial begin
    forever begin
      @(negedge wb_clk);
      if (wb_reset) begin
        got_n = 0;
        cap_pend = 0;
      end else begin
        if (cap_pend) begin
          got_mosi[got_n] = bus.mosi;
          got_n++;
        end
        cap_pend = 0;
        if (exp_q.size() > 0 && got_n < exp_q[0].n &&
            (exp_q[0].tx_neg ? bus.neg_edge : bus.pos_edge))
          cap_pend = 1;
        if (bus.done) begin
          if (exp_q.size() == 0) begin
            check("unexpected_done", DW'(1), DW'(0));
          end else begin
            e_mon = exp_q.pop_front();
            msk = (e_mon.n >= DW) ? '1 : ((DW'(1) << e_mon.n) - DW'(1));
            check("done_pout", bus.p_out, e_mon.pout_exp);
            check("done_bits", DW'(got_n), DW'(e_mon.n));
            check("done_mosi", got_mosi & msk, e_mon.mosi_exp & msk);
            check("done_tip", DW'(bus.tip), DW'(0));
          end
          got_n = 0;
        end
      end
    end
  end

  task automatic do_wr(input logic [BW-1:0] sel, input logic [DW-1:0] din);
    bus.wr = 1'b1;
    bus.byte_sel = sel;
    bus.p_in = din;
    tick();
    bus.wr = 1'b0;
    model_d = merge(model_d, sel, din);
  endtask

  // One transfer. loop_src: the sampled bit is the driven bit (external or
  // internal loopback). abort_at >= 0 resets before that bit pair.
  task automatic do_xfer(input int len_f, input bit lsb, input bit txn, input bit rxn,
                         input bit loop_src, input logic [DW-1:0] pat, input int abort_at,
                         input bit wr_in_shift, input bit go_in_shift, input bit wr_go);
    int            n, p;
    logic          mb;
    logic [DW-1:0] newd;
    logic [BW-1:0] sel;
    logic [DW-1:0] din;
    exp_t          e;
    n = (len_f == 0) ? DW : len_f;
    sel = BW'($urandom);
    din = $urandom;
    if (wr_go) model_d = merge(model_d, sel, din);
    newd = model_d;
    e.n = n;
    e.tx_neg = txn;
    e.mosi_exp = '0;
    for (int k = 0; k < n; k++) begin
      p  = lsb ? k : n - 1 - k;
      mb = loop_src ? model_d[p] : pat[k];
      e.mosi_exp[k] = (!txn && rxn) ? mb : model_d[p];
      newd[p] = mb;
    end
    e.pout_exp = newd;
    if (abort_at < 0) exp_q.push_back(e);

    bus.go = 1'b1;
    bus.len = LW'(len_f);
    bus.lsb = lsb;
    bus.tx_negedge = txn;
    bus.rx_negedge = rxn;
    bus.wr = wr_go;
    bus.byte_sel = sel;
    bus.p_in = din;
    tick();
    bus.go = 1'b0;
    bus.wr = 1'b0;

    if (wr_in_shift) begin
      bus.wr = 1'b1;
      bus.byte_sel = '1;
      bus.p_in = ~model_d;
      tick();
      bus.wr = 1'b0;
      @(negedge wb_clk);
      check("wr_in_shift", bus.p_out, model_d);
      tick();
    end

    for (int k = 0; k < n; k++) begin
      if (k == abort_at) begin
        wb_reset = 1'b1;
        tick();
        wb_reset = 1'b0;
        @(negedge wb_clk);
        check("abort_tip", DW'(bus.tip), DW'(0));
        check("abort_pout", bus.p_out, '0);
        check("abort_mosi", DW'(bus.mosi), DW'(0));
        check("abort_done", DW'(bus.done), DW'(0));
        model_d = '0;
        repeat (4) tick();
        return;
      end
      repeat ($urandom_range(0, 2)) begin
        if (go_in_shift) begin
          bus.go = 1'b1;
          bus.len = LW'($urandom);
        end
        tick();
        bus.go = 1'b0;
      end
      if (!loop_src) miso_drv = pat[k];
      bus.neg_edge = 1'b1;
      tick();
      bus.neg_edge = 1'b0;
      bus.pos_edge = 1'b1;
      if (txn && !rxn && k == n - 1) begin
        @(negedge wb_clk);
        check("last_high", DW'(bus.last), DW'(1));
        check("tip_before_done", DW'(bus.tip), DW'(1));
      end
      tick();
      bus.pos_edge = 1'b0;
    end
    repeat (4) tick();
    model_d = newd;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.go = 1'b0;
    bus.len = '0;
    bus.lsb = 1'b0;
    bus.tx_negedge = 1'b0;
    bus.rx_negedge = 1'b0;
    bus.pos_edge = 1'b0;
    bus.neg_edge = 1'b0;
    bus.wr = 1'b0;
    bus.byte_sel = '0;
    bus.p_in = '0;
`ifdef SPI_SHIFT_LOOPBACK_EN
    bus.loop_en = 1'b0;
`endif
    ext_loop = 1'b0;
    miso_drv = 1'b0;
    model_d = '0;
    wb_reset = 1'b1;
    repeat (3) tick();
    @(negedge wb_clk);
    check("reset_pout", bus.p_out, '0);
    check("reset_mosi", DW'(bus.mosi), DW'(0));
    check("reset_tip", DW'(bus.tip), DW'(0));
    check("reset_done", DW'(bus.done), DW'(0));
    check("reset_last", DW'(bus.last), DW'(0));
    tick();
    wb_reset = 1'b0;
    tick();

    // Byte-enabled write while idle, then a write during SHIFT that must not land.
    do_wr(4'b0101, 32'h1122_3344);
    @(negedge wb_clk);
    check("wr_byte_sel", bus.p_out, 32'h0022_0044);
    tick();
    do_xfer(8, 1'b0, 1'b1, 1'b0, 1'b0, DW'($urandom), -1, 1'b1, 1'b0, 1'b0);

    // 0xA5 MSB first with miso looped to mosi: mosi 1,0,1,0,0,1,0,1.
    do_wr('1, 32'h0000_00A5);
    ext_loop = 1'b1;
    do_xfer(8, 1'b0, 1'b1, 1'b0, 1'b1, '0, -1, 1'b0, 1'b0, 1'b0);
    ext_loop = 1'b0;
    @(negedge wb_clk);
    check("a5_pout", bus.p_out, 32'h0000_00A5);
    tick();

    // Full width, LSB first, miso tied high over zero data.
    do_wr('1, '0);
    do_xfer(0, 1'b1, 1'b1, 1'b0, 1'b0, '1, -1, 1'b0, 1'b0, 1'b0);

    // Reset after 3 bits, then a fresh transfer.
    do_xfer(8, 1'b0, 1'b1, 1'b0, 1'b0, DW'($urandom), 3, 1'b0, 1'b0, 1'b0);
    do_xfer(8, 1'b0, 1'b1, 1'b0, 1'b0, DW'($urandom), -1, 1'b0, 1'b0, 1'b0);

    // go while busy is ignored; go+wr in the same idle cycle starts from new data.
    do_xfer(16, 1'b1, 1'b0, 1'b1, 1'b0, DW'($urandom), -1, 1'b0, 1'b1, 1'b0);
    do_xfer(12, 1'b0, 1'b0, 1'b0, 1'b0, DW'($urandom), -1, 1'b0, 1'b0, 1'b1);

`ifdef SPI_SHIFT_LOOPBACK_EN
    do_wr('1, 32'h0000_003C);
    bus.loop_en = 1'b1;
    miso_drv = 1'b0;
    do_xfer(8, 1'b0, 1'b1, 1'b0, 1'b1, '0, -1, 1'b0, 1'b0, 1'b0);
    bus.loop_en = 1'b0;
    @(negedge wb_clk);
    check("loopback_pout", bus.p_out, 32'h0000_003C);
    tick();
`endif

    for (int t = 0; t < 30; t++) begin
      if ($urandom_range(0, 1) == 1) do_wr(BW'($urandom), DW'($urandom));
      do_xfer(int'($urandom_range(0, DW - 1)), 1'($urandom), 1'($urandom), 1'($urandom),
              1'b0, DW'($urandom), -1, 1'($urandom_range(0, 3) == 0),
              1'($urandom), 1'($urandom_range(0, 3) == 0));
    end

    repeat (5) tick();
    check("scoreboard_empty", DW'(exp_q.size()), '0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_shift_xfer.md
SPI_SHIFT_XFER -- requirements
Module: spi_shift_xfer

Interface
REQ-001 Parameter DATA_W, default 32, maximum character length in bits; multiple of 8, range 8..128.
REQ-002 Parameter LEN_W, default $clog2(DATA_W), width of the length field.
REQ-003 wb_clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 wb_reset  in  1  reset, synchronous, active-high.
REQ-005 go  in  1  start-transfer request, sampled in IDLE only.
REQ-006 len  in  LEN_W  character length in bits; 0 encodes DATA_W.
REQ-007 lsb  in  1  1 = LSB first, 0 = MSB first; sampled at go.
REQ-008 tx_negedge, rx_negedge  in  1 each  select neg_edge (1) or pos_edge (0) as the drive/sample strobe; sampled at go.
REQ-009 pos_edge, neg_edge  in  1 each  single-cycle SCLK edge strobes from the clock generator.
REQ-010 miso  in  1  serial input.
REQ-011 wr  in  1  parallel write strobe.
REQ-012 byte_sel  in  DATA_W/8  byte enables for wr.
REQ-013 p_in  in  DATA_W  parallel write data.
REQ-014 p_out  out  DATA_W  shift register contents.
REQ-015 mosi  out  1  serial output, registered.
REQ-016 tip  out  1  transfer in progress.
REQ-017 last  out  1  all bits driven (tip && tx_cnt==0).
REQ-018 done  out  1  single-cycle transfer-complete pulse.

Function
REQ-019 FSM states IDLE, SHIFT, DONE; tip=1 exactly in SHIFT.
REQ-020 IDLE: wr loads byte k of the data register from p_in[8k+7:8k] wherever byte_sel[k]=1; other bytes hold.
REQ-021 IDLE & go: next cycle SHIFT; tx_cnt and rx_cnt load N = (len==0 ? DATA_W : len); lsb and the edge selects are latched.
REQ-022 go and wr in the same IDLE cycle: wr applies, and the transfer starts from the updated data.
REQ-023 SHIFT: on the tx strobe with tx_cnt!=0, mosi <= data[tx_idx] and tx_cnt decrements.
REQ-024 SHIFT: on the rx strobe with rx_cnt!=0, data[rx_idx] <= miso and rx_cnt decrements.
REQ-025 Index rule for counter c: MSB-first idx = c-1; LSB-first idx = N-c. Arithmetic is LEN_W+1 bits wide, so N = DATA_W does not overflow.
REQ-026 Strobes that are not selected have no effect. If tx and rx strobes coincide, both actions occur in the same cycle.
REQ-027 SHIFT -> DONE in the cycle after rx_cnt reaches 0; DONE lasts one cycle with done=1; DONE -> IDLE unconditionally.
REQ-028 wr and go are ignored outside IDLE; p_out is readable at all times.
REQ-029 mosi holds its last driven value outside SHIFT.

Reset
REQ-030 wb_reset=1 forces the IDLE state: data=0, mosi=0, tip=0, done=0, tx_cnt=0, rx_cnt=0; last=0 follows from tip=0.
REQ-031 Reset mid-transfer aborts immediately without a done pulse; reset has priority over every other input.

Configuration
REQ-032 Macro SPI_SHIFT_LOOPBACK_EN: when defined, add input loop_en (1 bit); with loop_en=1, the rx sample source is the internally registered mosi instead of miso.
REQ-033 Without SPI_SHIFT_LOOPBACK_EN, the loop_en port does not exist and miso is always the sample source.

Structure
REQ-034 The shared package spi_pkg holds the FSM state enum, DATA_W legality constants, and the len-to-N decode function.
REQ-035 One sub-module, spi_bit_ctr, implements a loadable down-counter with a zero flag and index output; it is instantiated twice (tx, rx).

Verification
REQ-036 DATA_W=32, len=8, MSB first, tx_negedge=1, rx_negedge=0, data=0xA5, miso loops mosi externally -> mosi sequence 1,0,1,0,0,1,0,1; p_out[7:0]=0xA5; one done pulse.
REQ-037 len=0, LSB first, miso tied 1, data=0 -> 32 bits shifted; mosi all 0; p_out=0xFFFF_FFFF; tip high until DONE.
REQ-038 wr with byte_sel=4'b0101, p_in=0x11223344 over data=0 -> p_out=0x00220044; the same wr issued during SHIFT -> p_out unchanged.
REQ-039 wb_reset asserted after 3 bits of an 8-bit transfer -> next cycle tip=0, p_out=0, mosi=0, no done; a subsequent go starts a fresh transfer.
REQ-040 go asserted while tip=1 -> ignored; done pulses exactly once per accepted go.
REQ-041 SPI_SHIFT_LOOPBACK_EN defined, loop_en=1, miso tied 0, data=0x3C, len=8 -> p_out[7:0]=0x3C after DONE.
